// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with a tear-free frame handshake.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scanner #(
  parameter int N_DIGITS     = 8,
  parameter int PRESCALE     = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*N_DIGITS-1:0]   data_i,
  input  logic [N_DIGITS-1:0]     dp_mask_i,
  input  logic [N_DIGITS-1:0]     en_mask_i,
  output logic [3:0]              bcd_o,
  output logic                    dp_o,
  output logic [N_DIGITS-1:0]     an_o,
  output logic                    ack_o,
  output logic                    frame_o
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(N_DIGITS);

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [4*N_DIGITS-1:0]   actData_q, actData_d;
  logic [N_DIGITS-1:0]     actDp_q, actDp_d;
  logic [N_DIGITS-1:0]     actEn_q, actEn_d;
  logic [4*N_DIGITS-1:0]   pendData_q, pendData_d;
  logic [N_DIGITS-1:0]     pendDp_q, pendDp_d;
  logic [N_DIGITS-1:0]     pendEn_q, pendEn_d;
  logic                    pendVld_q, pendVld_d;

  logic [N_DIGITS-1:0]     an_q, an_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    dp_q, dp_d;
  logic                    ack_q, ack_d;
  logic                    frame_q, frame_d;

  logic                    slotEnd, guardEnd, wrap, transfer;
  logic [N_DIGITS-1:0]     blankMask;
  logic [3:0]              actNib [N_DIGITS];

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
    assign actNib[g] = actData_q[4*g +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k blanks when it and every digit above it are zero; digit 0 always shows.
  logic [N_DIGITS-1:0]     blank_q, blank_d;
  logic [N_DIGITS:1]       zeroAbove;

  assign zeroAbove[N_DIGITS] = 1'b1;
  for (genvar g = 1; g < N_DIGITS; g++) begin : g_zero
    assign zeroAbove[g] = zeroAbove[g+1] & (pendData_q[4*g +: 4] == 4'h0);
  end

  assign blank_d   = transfer ? {zeroAbove[N_DIGITS-1:1], 1'b0} : blank_q;
  assign blankMask = blank_q;

  always_ff @(posedge clk) begin
    if (!rst_n) blank_q <= {{(N_DIGITS-1){1'b1}}, 1'b0};
    else        blank_q <= blank_d;
  end
`else
  assign blankMask = '0;
`endif

  always_comb begin
    slotEnd  = (cnt_q == CNT_W'(PRESCALE - 1));
    guardEnd = (cnt_q == CNT_W'(GUARD_CYCLES - 1));
    wrap     = slotEnd && (idx_q == IDX_W'(N_DIGITS - 1));
    transfer = wrap && pendVld_q;

    cnt_d = slotEnd ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slotEnd) idx_d = wrap ? '0 : idx_q + 1'b1;

    state_d = state_q;
    case (state_q)
      GUARD:   if (guardEnd) state_d = DRIVE;
      DRIVE:   if (slotEnd)  state_d = GUARD;
      default: state_d = GUARD;
    endcase

    actData_d = transfer ? pendData_q : actData_q;
    actDp_d   = transfer ? pendDp_q   : actDp_q;
    actEn_d   = transfer ? pendEn_q   : actEn_q;

    // A load coincident with the wrap lands in pending after the old value moves out.
    pendData_d = load_i ? data_i    : pendData_q;
    pendDp_d   = load_i ? dp_mask_i : pendDp_q;
    pendEn_d   = load_i ? en_mask_i : pendEn_q;
    pendVld_d  = load_i | (pendVld_q & ~transfer);

    // Transfers only happen entering GUARD, so the current active masks are safe here.
    an_d = '1;
    if (state_d == DRIVE && actEn_q[idx_d] && !blankMask[idx_d]) an_d[idx_d] = 1'b0;

    bcd_d   = actNib[idx_q];
    dp_d    = ~actDp_q[idx_q];
    ack_d   = transfer;
    frame_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= GUARD;
      cnt_q      <= '0;
      idx_q      <= '0;
      actData_q  <= '0;
      actDp_q    <= '0;
      actEn_q    <= '0;
      pendData_q <= '0;
      pendDp_q   <= '0;
      pendEn_q   <= '0;
      pendVld_q  <= 1'b0;
      an_q       <= '1;
      bcd_q      <= 4'h0;
      dp_q       <= 1'b1;
      ack_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      actData_q  <= actData_d;
      actDp_q    <= actDp_d;
      actEn_q    <= actEn_d;
      pendData_q <= pendData_d;
      pendDp_q   <= pendDp_d;
      pendEn_q   <= pendEn_d;
      pendVld_q  <= pendVld_d;
      an_q       <= an_d;
      bcd_q      <= bcd_d;
      dp_q       <= dp_d;
      ack_q      <= ack_d;
      frame_q    <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign bcd_o   = bcd_q;
  assign dp_o    = dp_q;
  assign ack_o   = ack_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: cycle-count reference model plus directed literal checks.
// Mirrors LEADING_ZERO_BLANK_EN in the model when the macro is defined for the build.
module tb_display_scanner;
  localparam int N     = 4;
  localparam int P     = 8;
  localparam int G     = 2;
  localparam int FRAME = N * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  dp_mask_i = '0;
  logic [3:0]  en_mask_i = '0;
  logic [3:0]  bcd_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        ack_o;
  logic        frame_o;

  display_scanner #(.N_DIGITS(N), .PRESCALE(P), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .data_i(data_i),
    .dp_mask_i(dp_mask_i), .en_mask_i(en_mask_i), .bcd_o(bcd_o), .dp_o(dp_o),
    .an_o(an_o), .ack_o(ack_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: everything derives from n, the number of cycles since reset.
  bit          modelValid = 1'b0;
  int          n = 0;
  logic [15:0] mData, mPend;
  logic [3:0]  mDp, mEn, mPDp, mPEn;
  bit          mPv;
  logic [3:0]  expAn = 4'hF;
  logic [3:0]  expBcd = 4'h0;
  logic        expDp = 1'b1;
  logic        expAck = 1'b0;
  logic        expFrame = 1'b0;

  function automatic bit blanked(input int k, input logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    if (k == 0) return 1'b0;
    for (int j = k; j < N; j++)
      if (((d >> (4*j)) & 16'hF) != 16'h0) return 1'b0;
    return 1'b1;
`else
    return (k < 0) && (d == 16'h0);
`endif
  endfunction

  always @(posedge clk) begin
    int  idx, idx2, cnt;
    bit  wrap;
    if (!rst_n) begin
      n = 0; mData = '0; mPend = '0; mDp = '0; mEn = '0; mPDp = '0; mPEn = '0; mPv = 1'b0;
      expAn = 4'hF; expBcd = 4'h0; expDp = 1'b1; expAck = 1'b0; expFrame = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      idx      = (n / P) % N;
      wrap     = ((n + 1) % FRAME) == 0;
      expBcd   = 4'((mData >> (4*idx)) & 16'hF);
      expDp    = ~mDp[idx];
      expFrame = wrap;
      expAck   = wrap && mPv;
      if (wrap && mPv) begin
        mData = mPend; mDp = mPDp; mEn = mPEn; mPv = 1'b0;
      end
      if (load_i) begin
        mPend = data_i; mPDp = dp_mask_i; mPEn = en_mask_i; mPv = 1'b1;
      end
      n++;
      cnt  = n % P;
      idx2 = (n / P) % N;
      expAn = 4'hF;
      if (cnt >= G && mEn[idx2] && !blanked(idx2, mData)) expAn[idx2] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model_an", an_o, expAn);
      checkOutput("model_bcd", bcd_o, expBcd);
      checkOutput("model_dp", dp_o, expDp);
      checkOutput("model_ack", ack_o, expAck);
      checkOutput("model_frame", frame_o, expFrame);
    end
  end

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    load_i = 1'b1; data_i = d; dp_mask_i = dp; en_mask_i = en;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic waitPulse(input bit useAck, input int budget, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(useAck ? ack_o : frame_o) && k < budget);
    if (!(useAck ? ack_o : frame_o)) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout actual=none required=pulse within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int cntA, cntB;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: blank anodes, frame pulse every 32 cycles.
    cntA = 0; cntB = 0;
    repeat (64) begin
      @(negedge clk);
      if (frame_o) cntA++;
      if (an_o != 4'hF) cntB++;
    end
    checkOutput("idle_frames", cntA, 2);
    checkOutput("idle_anodes_lit", cntB, 0);

    // Basic frame 4321 with dp on digit 2.
    applyStimulus(16'h4321, 4'b0100, 4'hF);
    waitPulse(1'b1, 3*FRAME, "ack_4321");
    checkOutput("ack_with_frame", frame_o, 1);
    @(negedge clk);
    checkOutput("guard_an", an_o, 4'hF);
    checkOutput("guard_bcd", bcd_o, 4'h1);
    @(negedge clk);
    checkOutput("d0_an", an_o, 4'b1110);
    checkOutput("d0_bcd", bcd_o, 4'h1);
    repeat (P) @(negedge clk);
    checkOutput("d1_an", an_o, 4'b1101);
    checkOutput("d1_bcd", bcd_o, 4'h2);
    repeat (P) @(negedge clk);
    checkOutput("d2_an", an_o, 4'b1011);
    checkOutput("d2_bcd", bcd_o, 4'h3);
    checkOutput("d2_dp", dp_o, 0);
    repeat (P) @(negedge clk);
    checkOutput("d3_an", an_o, 4'b0111);
    checkOutput("d3_bcd", bcd_o, 4'h4);
    checkOutput("d3_dp", dp_o, 1);

    // Two loads in one frame: only the last survives, one ack.
    waitPulse(1'b0, 2*FRAME, "frame_before_double");
    repeat (2) @(negedge clk);
    applyStimulus(16'h1111, 4'h0, 4'hF);
    repeat (5) @(negedge clk);
    applyStimulus(16'h2222, 4'h0, 4'hF);
    waitPulse(1'b1, 2*FRAME, "ack_double");
    repeat (2) @(negedge clk);
    checkOutput("double_bcd", bcd_o, 4'h2);
    checkOutput("double_an", an_o, 4'b1110);
    cntA = 0;
    repeat (60) begin
      @(negedge clk);
      if (ack_o) cntA++;
    end
    checkOutput("double_extra_acks", cntA, 0);

    // Load in the wrap cycle: prior pending acked now, new data one frame later.
    waitPulse(1'b0, 2*FRAME, "frame_before_wrapload");
    repeat (5) @(negedge clk);
    applyStimulus(16'h8765, 4'h0, 4'hF);
    repeat (25) @(negedge clk);
    applyStimulus(16'h0987, 4'h0, 4'hF);
    checkOutput("wrap_ack1", ack_o, 1);
    checkOutput("wrap_frame1", frame_o, 1);
    repeat (2) @(negedge clk);
    checkOutput("wrap_bcd_old", bcd_o, 4'h5);
    waitPulse(1'b1, FRAME + 2, "ack_wrap_second");
    repeat (2) @(negedge clk);
    checkOutput("wrap_bcd_new", bcd_o, 4'h7);

    // Reset mid DRIVE discards pending and clears outputs.
    waitPulse(1'b0, 2*FRAME, "frame_before_reset");
    applyStimulus(16'hAAAA, 4'hF, 4'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_an", an_o, 4'hF);
    checkOutput("rst_dp", dp_o, 1);
    checkOutput("rst_bcd", bcd_o, 4'h0);
    cntA = 0;
    repeat (80) begin
      @(negedge clk);
      if (ack_o) cntA++;
    end
    checkOutput("rst_pending_acks", cntA, 0);

    // Randomized loads and occasional resets against the model.
    repeat (1500) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 19) == 0) begin
        load_i    = 1'b1;
        data_i    = 16'($urandom) & 16'($urandom);
        dp_mask_i = 4'($urandom);
        en_mask_i = 4'($urandom);
      end else begin
        load_i = 1'b0;
      end
    end
    load_i = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
